pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, SHALL set the number of bubble cycles inserted per load-use hazard (legal 1..3).
REQ-002 Parameter DRAIN_MAX, default 8, SHALL set the maximum number of DRAIN cycles before drain_err is raised.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_type  in  3  ID instruction class: 000 RR, 001 RM, 010 LOAD, 011 STORE, 100 BRANCH, 101 HALT.
REQ-007 id_rs, id_rt  in  5 each  ID source register fields.
REQ-008 ex_valid, ex_type, ex_dst  in  1/3/5  EX stage valid, class, destination register.
REQ-009 ex_taken_branch  in  1  branch in EX resolved taken this cycle.
REQ-010 wb_halted  in  1  writeback stage has retired HALT.
REQ-011 pc_en, ifid_en  out  1 each  PC and IF/ID register load enables.
REQ-012 ifid_flush, idex_bubble  out  1 each  squash IF/ID; load a NOP into ID/EX.
REQ-013 halted, drain_err  out  1 each  processor halted; drain timeout.
REQ-014 state  out  2  current FSM state; stall_count  out  16  performance counter.

Function
REQ-015 FSM states SHALL be RUN=0, STALL=1, DRAIN=2, HALTED=3; state is registered, other outputs are combinational from state and inputs.
REQ-016 Load-use hazard SHALL be ex_valid & ex_type==010 & ex_dst!=0 & (id_valid & (id_rs==ex_dst | (id_rt==ex_dst & id_type in {000,011}))).
REQ-017 RUN, no event: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
REQ-018 RUN with ex_taken_branch SHALL assert pc_en=1, ifid_flush=1, idex_bubble=1 in the same cycle and remain in RUN; branch has priority over hazard and HALT.
REQ-019 RUN with hazard (no branch) SHALL assert pc_en=0, ifid_en=0, idex_bubble=1 that cycle; if LOAD_STALL>1 go to STALL with down-counter = LOAD_STALL-1, else stay RUN.
REQ-020 STALL SHALL hold pc_en=0, ifid_en=0, idex_bubble=1, decrement the counter each cycle, and return to RUN in the cycle after the counter reaches 1.
REQ-021 RUN with id_valid & id_type==101 (no branch, no hazard) SHALL assert pc_en=0, ifid_en=1 (HALT passes to EX) and go to DRAIN with drain counter cleared.
REQ-022 DRAIN SHALL assert pc_en=0, ifid_flush=1, idex_bubble=1 and increment the drain counter each cycle.
REQ-023 DRAIN with ex_taken_branch (older branch squashes HALT) SHALL assert pc_en=1, ifid_flush=1, idex_bubble=1 and return to RUN.
REQ-024 DRAIN with wb_halted SHALL go to HALTED; wb_halted has priority over drain timeout.
REQ-025 DRAIN with counter reaching DRAIN_MAX SHALL set drain_err (sticky until reset) and go to HALTED.
REQ-026 HALTED SHALL hold pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, halted=1 until reset; all inputs ignored.
REQ-027 halted SHALL be 1 only in HALTED.

Reset
REQ-028 rst_n=0 at posedge clk SHALL force state=RUN, counters=0, drain_err=0, stall_count=0, from any state including mid-STALL or DRAIN.
REQ-029 During reset cycles outputs SHALL equal RUN no-event values with halted=0.

Configuration
REQ-030 With PIPE_CTRL_PERF_EN defined, stall_count SHALL increment by 1 each cycle with pc_en=0 in RUN or STALL, saturating at 16'hFFFF.
REQ-031 Without PIPE_CTRL_PERF_EN, stall_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-032 EX LOAD ex_dst=5, ID RR id_rs=5, LOAD_STALL=1 -> one cycle pc_en=0, idex_bubble=1; next cycle RUN.
REQ-033 Same with LOAD_STALL=3 -> exactly 3 bubble cycles, state 0,1,1,0; ex_dst=0 -> no stall.
REQ-034 ex_taken_branch=1 together with hazard in RUN -> ifid_flush=1, idex_bubble=1, pc_en=1, no stall.
REQ-035 HALT in ID, wb_halted after 3 cycles -> DRAIN 3 cycles, then halted=1, pc_en=0 held for 10 further cycles.
REQ-036 HALT in ID, wb_halted never, DRAIN_MAX=8 -> HALTED after 8 DRAIN cycles, drain_err=1; rst_n=0 one cycle -> RUN, drain_err=0.
REQ-037 PIPE_CTRL_PERF_EN defined, 4 hazards at LOAD_STALL=2 -> stall_count=8; undefined -> 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller with HALT drain sequencing.
// Optional stall performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int DRAIN_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_type,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_valid,
  input  logic [2:0]  ex_type,
  input  logic [4:0]  ex_dst,
  input  logic        ex_taken_branch,
  input  logic        wb_halted,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted,
  output logic        drain_err,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  localparam int DW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    stall_cnt_r;
  logic [1:0]    stall_cnt_nxt_s;
  logic [DW-1:0] drain_cnt_r;
  logic [DW-1:0] drain_cnt_nxt_s;
  logic          drain_err_r;
  logic          err_set_s;
  logic          rt_used_s;
  logic          hazard_s;
  logic          halt_id_s;
  logic          pc_en_s;
  logic          ifid_en_s;
  logic          ifid_flush_s;
  logic          idex_bubble_s;
  logic          halted_s;

  // rt is only a true source operand for register-register ops and stores
  assign rt_used_s = (id_type == 3'b000) || (id_type == 3'b011);
  assign hazard_s  = ex_valid && (ex_type == 3'b010) && (ex_dst != 5'd0) && id_valid &&
                     ((id_rs == ex_dst) || ((id_rt == ex_dst) && rt_used_s));
  assign halt_id_s = id_valid && (id_type == 3'b101);

  // Next-state and pipeline control decode
  always_comb begin
    state_nxt_s     = state_r;
    stall_cnt_nxt_s = stall_cnt_r;
    drain_cnt_nxt_s = drain_cnt_r;
    err_set_s       = 1'b0;
    pc_en_s         = 1'b1;
    ifid_en_s       = 1'b1;
    ifid_flush_s    = 1'b0;
    idex_bubble_s   = 1'b0;
    halted_s        = 1'b0;
    case (state_r)
      RUN: begin
        if (ex_taken_branch) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
        end else if (hazard_s) begin
          pc_en_s       = 1'b0;
          ifid_en_s     = 1'b0;
          idex_bubble_s = 1'b1;
          if (LOAD_STALL > 1) begin
            state_nxt_s     = STALL;
            stall_cnt_nxt_s = 2'(LOAD_STALL - 1);
          end else begin
            stall_cnt_nxt_s = 2'd0;
          end
        end else if (halt_id_s) begin
          // HALT moves on to EX while fetch stops
          pc_en_s         = 1'b0;
          state_nxt_s     = DRAIN;
          drain_cnt_nxt_s = {DW{1'b0}};
        end else begin
          state_nxt_s = RUN;
        end
      end
      STALL: begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        idex_bubble_s = 1'b1;
        if (stall_cnt_r == 2'd1) begin
          state_nxt_s     = RUN;
          stall_cnt_nxt_s = 2'd0;
        end else begin
          stall_cnt_nxt_s = stall_cnt_r - 2'd1;
        end
      end
      DRAIN: begin
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
        if (ex_taken_branch) begin
          state_nxt_s = RUN;
        end else begin
          pc_en_s   = 1'b0;
          ifid_en_s = 1'b0;
          if (wb_halted) begin
            state_nxt_s = HALTED;
          end else if (drain_cnt_r == DW'(DRAIN_MAX - 1)) begin
            state_nxt_s = HALTED;
            err_set_s   = 1'b1;
          end else begin
            drain_cnt_nxt_s = drain_cnt_r + DW'(1);
          end
        end
      end
      HALTED: begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
        halted_s      = 1'b1;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= RUN;
      stall_cnt_r <= 2'd0;
      drain_cnt_r <= {DW{1'b0}};
      drain_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      drain_err_r <= drain_err_r | err_set_s;
    end
  end

  // While reset is held the pipeline sees plain RUN behaviour
  assign pc_en       = rst_n ? pc_en_s       : 1'b1;
  assign ifid_en     = rst_n ? ifid_en_s     : 1'b1;
  assign ifid_flush  = rst_n ? ifid_flush_s  : 1'b0;
  assign idex_bubble = rst_n ? idex_bubble_s : 1'b0;
  assign halted      = rst_n ? halted_s      : 1'b0;
  assign drain_err   = drain_err_r;
  assign state       = state_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_count_r;

  // Saturating count of fetch-stopped cycles in RUN or STALL
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_r <= 16'd0;
    end else if (!pc_en_s && ((state_r == RUN) || (state_r == STALL)) &&
                 (stall_count_r != 16'hFFFF)) begin
      stall_count_r <= stall_count_r + 16'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: three instances (LOAD_STALL 1..3) share
// stimulus and are compared every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int DMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_type;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_valid;
  logic [2:0]  ex_type;
  logic [4:0]  ex_dst;
  logic        ex_taken_branch;
  logic        wb_halted;

  logic        pc_en_w       [3];
  logic        ifid_en_w     [3];
  logic        ifid_flush_w  [3];
  logic        idex_bubble_w [3];
  logic        halted_w      [3];
  logic        drain_err_w   [3];
  logic [1:0]  state_w       [3];
  logic [15:0] stall_count_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_ctrl #(.LOAD_STALL(g + 1), .DRAIN_MAX(DMAX)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid        (id_valid),
      .id_type         (id_type),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .ex_valid        (ex_valid),
      .ex_type         (ex_type),
      .ex_dst          (ex_dst),
      .ex_taken_branch (ex_taken_branch),
      .wb_halted       (wb_halted),
      .pc_en           (pc_en_w[g]),
      .ifid_en         (ifid_en_w[g]),
      .ifid_flush      (ifid_flush_w[g]),
      .idex_bubble     (idex_bubble_w[g]),
      .halted          (halted_w[g]),
      .drain_err       (drain_err_w[g]),
      .state           (state_w[g]),
      .stall_count     (stall_count_w[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 run, 1 stall, 2 drain, 3 halted
  int m_mode  [3];
  int m_left  [3];
  int m_drain [3];
  int m_perf  [3];
  int m_err   [3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_hazard();
    bit rt_src;
    rt_src = (id_type == 3'd0) || (id_type == 3'd3);
    return ex_valid && (ex_type == 3'd2) && (ex_dst != 5'd0) && id_valid &&
           ((id_rs == ex_dst) || (rt_src && (id_rt == ex_dst)));
  endfunction

  // Expected {pc_en, ifid_en, ifid_flush, idex_bubble, halted}
  function automatic logic [4:0] exp_outs(input int mode);
    if (!rst_n) return 5'b11000;
    case (mode)
      0: begin
        if (ex_taken_branch) return 5'b11110;
        if (is_hazard()) return 5'b00010;
        if (id_valid && id_type == 3'd5) return 5'b01000;
        return 5'b11000;
      end
      1: return 5'b00010;
      2: return ex_taken_branch ? 5'b11110 : 5'b00110;
      default: return 5'b00111;
    endcase
  endfunction

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      logic [4:0] e;
      e = exp_outs(m_mode[k]);
      if (!rst_n) begin
        m_mode[k] = 0; m_left[k] = 0; m_drain[k] = 0; m_err[k] = 0; m_perf[k] = 0;
      end else begin
        if (!e[4] && m_mode[k] < 2 && m_perf[k] < 65535) m_perf[k]++;
        case (m_mode[k])
          0: begin
            if (ex_taken_branch) m_mode[k] = 0;
            else if (is_hazard()) begin
              if (k + 1 > 1) begin m_mode[k] = 1; m_left[k] = k; end
            end else if (id_valid && id_type == 3'd5) begin
              m_mode[k] = 2; m_drain[k] = 0;
            end
          end
          1: begin
            if (m_left[k] == 1) m_mode[k] = 0;
            else m_left[k]--;
          end
          2: begin
            if (ex_taken_branch) m_mode[k] = 0;
            else if (wb_halted) m_mode[k] = 3;
            else if (m_drain[k] + 1 >= DMAX) begin m_mode[k] = 3; m_err[k] = 1; end
            else m_drain[k]++;
          end
          default: m_mode[k] = 3;
        endcase
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [4:0] e;
      int perf_exp;
      e = exp_outs(m_mode[k]);
`ifdef PIPE_CTRL_PERF_EN
      perf_exp = m_perf[k];
`else
      perf_exp = 0;
`endif
      check_eq($sformatf("ls%0d_pc_en", k + 1),       32'(pc_en_w[k]),       32'(e[4]));
      check_eq($sformatf("ls%0d_ifid_en", k + 1),     32'(ifid_en_w[k]),     32'(e[3]));
      check_eq($sformatf("ls%0d_ifid_flush", k + 1),  32'(ifid_flush_w[k]),  32'(e[2]));
      check_eq($sformatf("ls%0d_idex_bubble", k + 1), 32'(idex_bubble_w[k]), 32'(e[1]));
      check_eq($sformatf("ls%0d_halted", k + 1),      32'(halted_w[k]),      32'(e[0]));
      check_eq($sformatf("ls%0d_state", k + 1),       32'(state_w[k]),       m_mode[k]);
      check_eq($sformatf("ls%0d_drain_err", k + 1),   32'(drain_err_w[k]),   m_err[k]);
      check_eq($sformatf("ls%0d_stall_count", k + 1), 32'(stall_count_w[k]), perf_exp);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic rn, input logic iv, input logic [2:0] it,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic ev, input logic [2:0] et, input logic [4:0] ed,
                       input logic br, input logic wb);
    rst_n = rn; id_valid = iv; id_type = it; id_rs = rs; id_rt = rt;
    ex_valid = ev; ex_type = et; ex_dst = ed; ex_taken_branch = br; wb_halted = wb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_left[k] = 0; m_drain[k] = 0; m_err[k] = 0; m_perf[k] = 0;
    end
    #1;
    do_reset(2);

    // Load-use hazard on rs, then ex_dst=0 (no hazard), then branch+hazard
    drive(1'b1, 1'b1, 3'd0, 5'd5, 5'd1, 1'b1, 3'd2, 5'd5, 1'b0, 1'b0); step();
    idle(3);
    drive(1'b1, 1'b1, 3'd0, 5'd0, 5'd0, 1'b1, 3'd2, 5'd0, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 3'd0, 5'd5, 5'd1, 1'b1, 3'd2, 5'd5, 1'b1, 1'b0); step();
    idle(1);
    // rt hazard only matters for RR/STORE
    drive(1'b1, 1'b1, 3'd1, 5'd1, 5'd7, 1'b1, 3'd2, 5'd7, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 3'd3, 5'd1, 5'd7, 1'b1, 3'd2, 5'd7, 1'b0, 1'b0); step();
    idle(3);

    // HALT with retirement after 3 drain cycles, then 10 halted cycles
    drive(1'b1, 1'b1, 3'd5, 5'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0); step();
    idle(2);
    drive(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1); step();
    idle(10);
    check_eq("halt_held", 32'(halted_w[0]), 32'd1);
    do_reset(1);

    // HALT never retires: timeout after DMAX drain cycles
    drive(1'b1, 1'b1, 3'd5, 5'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0); step();
    idle(DMAX + 2);
    check_eq("drain_timeout_err", 32'(drain_err_w[0]), 32'd1);
    do_reset(1);
    check_eq("err_cleared", 32'(drain_err_w[0]), 32'd0);
    idle(1);

    // Four hazards with LOAD_STALL=2 instance
    for (int h = 0; h < 4; h++) begin
      drive(1'b1, 1'b1, 3'd0, 5'd3, 5'd0, 1'b1, 3'd2, 5'd3, 1'b0, 1'b0); step();
      idle(2);
    end
`ifdef PIPE_CTRL_PERF_EN
    check_eq("perf_4x2", 32'(stall_count_w[1]), 32'd8);
`else
    check_eq("perf_off", 32'(stall_count_w[1]), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) != 0) ? 3'd2 : 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
